// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache fill arbiter.
// Block geometry and memory latency live here so both modules agree.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LAT     = 4;
    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int CNT_W       = $clog2(BLOCK_WORDS);
    localparam int BLK_W       = ADDR_W - CNT_W - 1;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [BLK_W-1:0] blk,
        input logic [CNT_W-1:0] k
    );
        return {blk, k, 1'b0};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Issue/receive word counters for one cache block fill.
// done marks the cycle the last word of the block comes back.
module fill_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             rcv,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic             issuing,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

    logic issued_all;

    assign issuing = busy && !issued_all;
    assign done    = busy && rcv && (rcv_cnt == LAST);

    // Issue counter parks at the last word until the block completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt  <= '0;
            issued_all <= 1'b0;
        end else if (done) begin
            issue_cnt  <= '0;
            issued_all <= 1'b0;
        end else if (issuing) begin
            if (issue_cnt == LAST) begin
                issued_all <= 1'b1;
            end else begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_cnt <= '0;
        end else if (busy && rcv) begin
            rcv_cnt <= rcv_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-miss fills, D-miss fills and write-through stores
// onto one pipelined main-memory port.
module mem_fill_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [WORD_W-1:0] fill_data,
    output logic [CNT_W-1:0]  fill_word,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic              fill_done_i,
    output logic              fill_done_d
);

    state_t            state;
    state_t            state_nxt;
    logic [BLK_W-1:0]  blk;
    logic [MEM_LAT-1:0] inflight;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rcv_cnt;
    logic              issuing;
    logic              done;
    logic              busy;
    logic              accept;

    assign busy = (state != IDLE);

    // Only data for reads issued by this fill is accepted; returns for
    // reads abandoned by a reset fall out of the shift register.
    assign accept = busy && mem_valid && inflight[MEM_LAT-1];

    fill_counter u_cnt (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .rcv       (accept),
        .issue_cnt (issue_cnt),
        .rcv_cnt   (rcv_cnt),
        .issuing   (issuing),
        .done      (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk <= '0;
        end else if (state == IDLE && !d_wr) begin
            if (d_miss) begin
                blk <= d_addr[ADDR_W-1:CNT_W+1];
            end else if (i_miss) begin
                blk <= i_addr[ADDR_W-1:CNT_W+1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= {inflight[MEM_LAT-2:0], issuing};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_wr) begin
                    state_nxt = IDLE;
                end else if (d_miss) begin
                    state_nxt = FILL_D;
                end else if (i_miss) begin
                    state_nxt = FILL_I;
                end
            end
            FILL_I, FILL_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        d_wr_ack    = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (d_wr) begin
                        d_wr_ack  = 1'b1;
                        mem_en    = 1'b1;
                        mem_wr    = 1'b1;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                    end
                end
                FILL_I, FILL_D: begin
                    mem_en = issuing;
                    if (issuing) begin
                        mem_addr = word_addr(blk, issue_cnt);
                    end
                    if (accept) begin
                        fill_data = mem_rdata;
                        fill_word = rcv_cnt;
                    end
                    fill_we_i   = accept && (state == FILL_I);
                    fill_we_d   = accept && (state == FILL_D);
                    fill_done_i = done && (state == FILL_I);
                    fill_done_d = done && (state == FILL_D);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports: clk (in, 1) system clock; rst (in, 1) async active-high reset.
REQ-002 The block SHALL have the following request ports: i_miss (in, 1) I-cache read miss; i_addr (in, 16) I-miss byte address; d_miss (in, 1) D-cache load miss; d_addr (in, 16) D-miss/store byte address; d_wr (in, 1) store request (opcode 1001, write-through, no allocate); d_wdata (in, 16) store data; d_wr_ack (out, 1) store accepted this cycle.
REQ-003 The block SHALL have the following memory ports: mem_en (out, 1); mem_wr (out, 1); mem_addr (out, 16); mem_wdata (out, 16); mem_rdata (in, 16); mem_valid (in, 1) read data returned.
REQ-004 The block SHALL have the following fill ports: fill_data (out, 16); fill_word (out, 3) word offset; fill_we_i (out, 1) / fill_we_d (out, 1) data-array write strobes; fill_done_i (out, 1) / fill_done_d (out, 1) one-cycle tag/valid write pulses.

Function
REQ-005 Main memory SHALL be treated as pipelined: one request per cycle; read data SHALL return with mem_valid exactly 4 cycles after its mem_en cycle, in order; writes return nothing.
REQ-006 A cache block SHALL be 8 words of 16 bits; word k byte address = {addr[15:4], k[2:0], 1'b0}.
REQ-007 The FSM SHALL have states IDLE, FILL_I, FILL_D.
REQ-008 In IDLE the request priority SHALL be d_wr > d_miss > i_miss.
REQ-009 In IDLE with d_wr=1, the block SHALL drive mem_en=mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata and d_wr_ack=1 combinationally in the same cycle, and SHALL remain in IDLE.
REQ-010 In IDLE with d_miss=1 and d_wr=0, the block SHALL latch d_addr[15:4] and enter FILL_D; with only i_miss=1, it SHALL latch i_addr[15:4] and enter FILL_I.
REQ-011 In FILL_x the block SHALL issue reads on 8 consecutive cycles (issue counter 0..7), with mem_en=1, mem_wr=0, with no gaps.
REQ-012 On each mem_valid in FILL_x the block SHALL drive fill_data=mem_rdata, fill_word=receive counter and fill_we_x=1, then increment the receive counter.
REQ-013 On the 8th returned word the block SHALL pulse fill_done_x in the same cycle and return to IDLE on the next edge.
REQ-014 Timing: a miss seen in IDLE at cycle N SHALL produce mem_en in cycles N+1..N+8, fill writes in cycles N+5..N+12, fill_done in cycle N+12, and IDLE in cycle N+13.
REQ-015 d_wr during FILL_x SHALL NOT be acked (d_wr_ack=0); the requester holds it.
REQ-016 Deassertion of i_miss/d_miss during a fill SHALL NOT abort the fill; the block completes it.
REQ-017 mem_valid in IDLE SHALL be ignored: no fill strobes.
REQ-018 The latched block address SHALL be used for the whole fill; input address changes are ignored.
REQ-019 Counters SHALL be 3 bits; the issue counter SHALL stop after 7 (no wrap-issue); the receive counter wraps to 0 on completion.

Reset
REQ-020 While rst=1 the block SHALL hold state IDLE with counters and latched address at 0, and all outputs 0, regardless of clk.
REQ-021 Reset mid-fill SHALL discard the partial fill without a fill_done pulse; memory data arriving after reset deassertion is ignored per REQ-017, and the still-asserted miss restarts the fill.

Structure
REQ-022 A shared package mem_arb_pkg SHALL hold the state enum (IDLE, FILL_I, FILL_D) and the constants BLOCK_WORDS=8, MEM_LAT=4 and ADDR_W=16.
REQ-023 The issue/receive counter pair with its completion flag SHALL be one sub-module, fill_counter; all other logic stays in mem_fill_arbiter.

Verification
REQ-024 d_miss=1, d_addr=0x1236 at cycle N -> mem_addr 0x1230,0x1232..0x123E in N+1..N+8; fill_we_d with fill_word 0..7 in N+5..N+12; fill_done_d=1 only in N+12.
REQ-025 d_wr=1, d_miss=1 and i_miss=1 together in IDLE -> cycle 0: write with d_wr_ack=1 and mem_wr=1; cycle 1: FILL_D begins; I-fill starts the cycle after fill_done_d.
REQ-026 d_wr=1, d_addr=0x0040, d_wdata=0xBEEF during FILL_I -> d_wr_ack=0 throughout; write issued in the first IDLE cycle after fill_done_i.
REQ-027 rst pulsed at N+6 of an I-fill -> outputs 0 immediately; no fill_done_i; stray mem_valid ignored; fill restarts when i_miss is still 1.
REQ-028 i_miss dropped at N+3 -> all 8 words still written, fill_done_i pulses at N+12.
